// File: rtl/cache_pkg.sv
// Shared definitions for the L1 cache-line fill controller.
//   - fill_state_e : fill FSM state encoding (IDLE / REQ / DRAIN)
//   - clog2()      : elaboration-time ceiling log2 used to size indices
//   - CACHE_*      : default address/data/line geometry
package cache_pkg;

  localparam int CACHE_ADDR_W = 16;
  localparam int CACHE_DATA_W = 16;
  localparam int CACHE_WORDS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a miss
    REQ   = 2'd1,  // issuing one word read per cycle
    DRAIN = 2'd2   // all reads issued, collecting outstanding responses
  } fill_state_e;

  // Smallest r with 2**r >= value (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for the fill controller (one instance for requests, one for
// responses).
//   clk, rst : clock / asynchronous active-low reset
//   clr      : synchronous clear (start of a new fill), wins over en
//   en       : count one word
//   start    : first word index of the line (critical word or 0)
//   count    : words counted so far, one bit wider so WORDS is representable
//   idx      : (start + count) mod WORDS, the word index to use this cycle
module fill_word_counter #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W:0]   count,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + {{IDX_W{1'b0}}, 1'b1};
    end
  end

  assign count = count_reg;
  // Truncating add gives the modulo-WORDS wrap for free.
  assign idx   = start + count_reg[IDX_W-1:0];

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache-line fill controller between the L1 tag/data arrays and the shared
// memory port. Requests for a whole line are issued on back-to-back cycles
// (optionally critical word first); in-order responses of any latency are
// written into the data array as they arrive.
//   clk, rst          : clock / asynchronous active-low reset
//   miss_detected     : miss this cycle, accepted only in IDLE
//   miss_addr         : missing byte address, latched on acceptance
//   mem_data_vld      : one returned word this cycle (request order)
//   mem_data          : returned word
//   mem_req           : read request to mem_address this cycle
//   mem_address       : read byte address (0 when no request)
//   fsm_busy          : fill in progress, pipeline stall
//   write_data_array  : write fill_data to the word selected by word_sel
//   word_sel          : one-hot word enable (0 when not writing)
//   fill_data         : mem_data passthrough
//   write_tag_array   : write tag/valid, with the last word only
//   fill_done         : one-cycle completion pulse, with the last word
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = CACHE_ADDR_W,
  parameter int DATA_W     = CACHE_DATA_W,
  parameter int WORDS      = CACHE_WORDS,
  parameter int BYTE_OFF_W = 1,
  parameter int CWF        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              mem_data_vld,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_address,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic [WORDS-1:0]  word_sel,
  output logic [DATA_W-1:0] fill_data,
  output logic              write_tag_array,
  output logic              fill_done
);

  localparam int IDX_W = clog2(WORDS);
  localparam int OFF_W = IDX_W + BYTE_OFF_W;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  fill_state_e       state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [IDX_W-1:0]  start_reg;
  logic [ADDR_W-1:0] base_next;
  logic [IDX_W-1:0]  start_next;

  logic              accept;
  logic              resp_fire;
  logic [CNT_W-1:0]  rq_count, rs_count;
  logic [IDX_W-1:0]  rq_idx, rs_idx;

  assign base_next  = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign start_next = (CWF != 0) ? miss_addr[OFF_W-1:BYTE_OFF_W] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      start_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        base_reg  <= base_next;
        start_reg <= start_next;
      end
    end
  end

  fill_word_counter #(.IDX_W(IDX_W)) u_rq_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (mem_req),
    .start (start_reg),
    .count (rq_count),
    .idx   (rq_idx)
  );

  fill_word_counter #(.IDX_W(IDX_W)) u_rs_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (resp_fire),
    .start (start_reg),
    .count (rs_count),
    .idx   (rs_idx)
  );

  always_comb begin
    state_next       = state_reg;
    accept           = 1'b0;
    mem_req          = 1'b0;
    resp_fire        = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (miss_detected) begin
          accept     = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        // A response beyond the line length can never be written.
        resp_fire = mem_data_vld && !rs_count[IDX_W];
        if (rq_count == LAST_CNT) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        resp_fire = mem_data_vld && !rs_count[IDX_W];
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (resp_fire) begin
      write_data_array = 1'b1;
      // Last word: publish the tag in the same cycle and finish, even if
      // that coincides with the final request.
      if (rs_count == LAST_CNT) begin
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
        state_next      = IDLE;
      end
    end
  end

  assign mem_address = mem_req ? (base_reg | (ADDR_W'(rq_idx) << BYTE_OFF_W)) : '0;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word_sel
    assign word_sel[gi] = write_data_array && (rs_idx == IDX_W'(gi));
  end

  // These two depend on live inputs, so they are gated by reset to keep every
  // output at 0 while the controller is held in reset.
  assign fsm_busy  = rst && ((state_reg != IDLE) || miss_detected);
  assign fill_data = rst ? mem_data : '0;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: three instances (CWF=1 8x16,
// CWF=0 8x16, CWF=1 4x32 with 4-byte words), one active at a time.
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        miss;
  logic [15:0] miss_addr;
  logic        mem_vld;
  logic [31:0] mem_data;
  int          dsel;      // active instance: 0 cwf, 1 linear, 2 4-word
  int          lat_mode;  // 0: fixed 3-cycle latency, 1: random 1..10
  bit          stray;
  int          cyc;
  int          n_vec, n_bad;

  // per-instance nets
  logic        c_req, l_req, w_req, c_busy, l_busy, w_busy;
  logic        c_wr, l_wr, w_wr, c_tag, l_tag, w_tag, c_done, l_done, w_done;
  logic [15:0] c_addr, l_addr, w_addr, c_fd, l_fd;
  logic [31:0] w_fd;
  logic [7:0]  c_sel, l_sel;
  logic [3:0]  w_sel;

  cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .BYTE_OFF_W(1), .CWF(1)) u_cwf (
    .clk(clk), .rst(rst), .miss_detected(miss && dsel == 0), .miss_addr(miss_addr),
    .mem_data_vld(mem_vld && dsel == 0), .mem_data(mem_data[15:0]),
    .mem_req(c_req), .mem_address(c_addr), .fsm_busy(c_busy), .write_data_array(c_wr),
    .word_sel(c_sel), .fill_data(c_fd), .write_tag_array(c_tag), .fill_done(c_done));

  cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .BYTE_OFF_W(1), .CWF(0)) u_lin (
    .clk(clk), .rst(rst), .miss_detected(miss && dsel == 1), .miss_addr(miss_addr),
    .mem_data_vld(mem_vld && dsel == 1), .mem_data(mem_data[15:0]),
    .mem_req(l_req), .mem_address(l_addr), .fsm_busy(l_busy), .write_data_array(l_wr),
    .word_sel(l_sel), .fill_data(l_fd), .write_tag_array(l_tag), .fill_done(l_done));

  cache_fill_ctrl #(.ADDR_W(16), .DATA_W(32), .WORDS(4), .BYTE_OFF_W(2), .CWF(1)) u_w4 (
    .clk(clk), .rst(rst), .miss_detected(miss && dsel == 2), .miss_addr(miss_addr),
    .mem_data_vld(mem_vld && dsel == 2), .mem_data(mem_data),
    .mem_req(w_req), .mem_address(w_addr), .fsm_busy(w_busy), .write_data_array(w_wr),
    .word_sel(w_sel), .fill_data(w_fd), .write_tag_array(w_tag), .fill_done(w_done));

  // outputs of the active instance, zero-extended
  logic        act_req, act_busy, act_wr, act_tag, act_done;
  logic [15:0] act_addr;
  logic [7:0]  act_sel;
  logic [31:0] act_fd;

  always_comb begin
    act_req = c_req; act_busy = c_busy; act_wr = c_wr; act_tag = c_tag; act_done = c_done;
    act_addr = c_addr; act_sel = c_sel; act_fd = {16'h0, c_fd};
    case (dsel)
      1: begin
        act_req = l_req; act_busy = l_busy; act_wr = l_wr; act_tag = l_tag; act_done = l_done;
        act_addr = l_addr; act_sel = l_sel; act_fd = {16'h0, l_fd};
      end
      2: begin
        act_req = w_req; act_busy = w_busy; act_wr = w_wr; act_tag = w_tag; act_done = w_done;
        act_addr = w_addr; act_sel = {4'h0, w_sel}; act_fd = w_fd;
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] mem_fn(input logic [15:0] a);
    return {~a, a ^ 16'h5A5A};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0]  sel;
    logic [31:0] data;
    bit          last;
  } wr_t;

  logic [15:0] exp_req[$];
  wr_t         exp_wr[$];
  logic [15:0] tab_a[8];
  logic [7:0]  tab_s[8];

  task automatic push_table(input int n);
    wr_t e;
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      exp_req.push_back(tab_a[k]);
      d = mem_fn(tab_a[k]);
      e.sel  = tab_s[k];
      e.data = (dsel == 2) ? d : {16'h0, d[15:0]};
      e.last = (k == n - 1);
      exp_wr.push_back(e);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  pend_t pend[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    pend_t p;
    mem_vld  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend.delete();
        mem_vld = 1'b0;
      end else begin
        if (act_req) begin
          p.addr = act_addr;
          p.due  = cyc + ((lat_mode == 0) ? 3 : int'($urandom_range(1, 10)));
          pend.push_back(p);
        end
        if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
          p        = pend.pop_front();
          mem_vld  = 1'b1;
          mem_data = mem_fn(p.addr);
        end else begin
          mem_vld  = stray;
          mem_data = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        if (act_req) begin
          if (exp_req.size() == 0) chk("unexpected_req", act_addr, 32'hFFFF_FFFF);
          else chk("mem_address", act_addr, exp_req.pop_front());
        end else begin
          chk("addr_without_req", act_addr, 0);
        end
        if (act_wr) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", {act_sel, 24'h0}, 32'hFFFF_FFFF);
          end else begin
            e = exp_wr.pop_front();
            chk("word_sel", act_sel, e.sel);
            chk("fill_data", act_fd, e.data);
            chk("tag_done", {act_tag, act_done}, {e.last, e.last});
          end
        end else begin
          chk("quiet_outputs", {act_tag, act_done, act_sel}, 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_miss(input logic [15:0] a);
    miss = 1'b1;
    miss_addr = a;
    #1;
    chk("busy_on_miss", act_busy, 1);
    @(negedge clk);
    #3;
    miss = 1'b0;
    miss_addr = 16'hFFFF;
  endtask

  task automatic wait_done(input bit noise, input bit chk_busy);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (noise && i == 2) begin miss = 1'b1; miss_addr = 16'h7770; end
      if (noise && i == 6) miss = 1'b0;
      if (chk_busy) chk("busy_during_fill", act_busy, 1);
      if (act_done) seen = 1;
    end
    if (!seen) chk("fill_done_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {act_req, act_wr, act_tag, act_done, act_busy}, 0);
    chk({name, "_addr"}, act_addr, 0);
    chk({name, "_sel"}, act_sel, 0);
    chk({name, "_data"}, act_fd, 0);
  endtask

  initial begin
    int nwr;
    rst = 1'b0; miss = 1'b1; miss_addr = 16'h1234; dsel = 0; lat_mode = 0;
    stray = 0; cyc = 0; n_vec = 0; n_bad = 0;

    // reset state of every instance, with a miss pending
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      dsel = d;
      #1;
      chk_all_zero("reset_state");
    end
    dsel = 0; miss = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #3;

    // 1: CWF, fixed latency 3
    tab_a = '{16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232};
    tab_s = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    push_table(8);
    do_miss(16'h1234);
    wait_done(0, 1);
    @(negedge clk); #3;

    // 2: linear order, busy window
    dsel = 1;
    tab_a = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
    tab_s = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    push_table(8);
    do_miss(16'h1234);
    wait_done(0, 1);
    @(negedge clk); #3;
    chk("busy_after_done", act_busy, 0);

    // 3: random latency, miss held mid-fill
    dsel = 0; lat_mode = 1;
    tab_a = '{16'h2A56, 16'h2A58, 16'h2A5A, 16'h2A5C, 16'h2A5E, 16'h2A50, 16'h2A52, 16'h2A54};
    tab_s = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
    push_table(8);
    do_miss(16'h2A56);
    wait_done(1, 1);
    @(negedge clk); #3;
    lat_mode = 0;

    // 4: reset after 5 responses, then a fresh fill
    tab_a = '{16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232};
    tab_s = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    push_table(8);
    do_miss(16'h1234);
    nwr = (act_wr) ? 1 : 0;
    for (int i = 0; i < 100 && nwr < 5; i++) begin
      @(negedge clk); #3;
      if (act_wr) nwr++;
    end
    chk("five_writes_seen", nwr, 5);
    #1;
    rst = 1'b0;
    miss = 1'b1;
    #1;
    chk_all_zero("reset_mid_fill");
    exp_req.delete();
    exp_wr.delete();
    repeat (2) begin
      @(negedge clk); #3;
      chk_all_zero("reset_held");
    end
    miss = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #3;
    chk("idle_after_reset", {act_req, act_busy}, 0);
    tab_a = '{16'h4000, 16'h4002, 16'h4004, 16'h4006, 16'h4008, 16'h400A, 16'h400C, 16'h400E};
    tab_s = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    push_table(8);
    do_miss(16'h4000);
    wait_done(0, 1);
    @(negedge clk); #3;

    // 5: 4-word line, 4-byte words
    dsel = 2;
    tab_a = '{16'h00F8, 16'h00FC, 16'h00F0, 16'h00F4, 16'h0, 16'h0, 16'h0, 16'h0};
    tab_s = '{8'h04, 8'h08, 8'h01, 8'h02, 8'h0, 8'h0, 8'h0, 8'h0};
    push_table(4);
    do_miss(16'h00F8);
    wait_done(0, 1);
    @(negedge clk); #3;

    // 6: stray valid in IDLE, then back-to-back misses
    dsel = 1;
    stray = 1;
    repeat (3) begin
      @(negedge clk); #3;
      chk("stray_no_write", act_wr, 0);
    end
    stray = 0;
    @(negedge clk); #3;
    tab_a = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
    tab_s = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    push_table(8);
    do_miss(16'h1234);
    wait_done(0, 0);
    @(negedge clk); #3;
    tab_a = '{16'h0A00, 16'h0A02, 16'h0A04, 16'h0A06, 16'h0A08, 16'h0A0A, 16'h0A0C, 16'h0A0E};
    push_table(8);
    do_miss(16'h0A0E);
    chk("b2b_req_next_cycle", act_req, 1);
    wait_done(0, 1);
    repeat (3) @(negedge clk);
    #3;

    chk("leftover_requests", exp_req.size(), 0);
    chk("leftover_writes", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
